// File: rtl/fetch_pc_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_if
// Brief    : Decode-to-fetch redirect bundle plus fetch PC / statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_if;
  logic        stall;
  logic [31:0] d_pc;
  logic [2:0]  br_type;
  logic [1:0]  jmp_type;
  logic        eq;
  logic        eqz;
  logic        ltz;
  logic        gtz;
  logic [15:0] imm16;
  logic [25:0] idx26;
  logic [31:0] rs_val;
  logic [31:0] f_pc;
  logic        taken;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;
  logic        f_adel;

  modport master (
    output stall, d_pc, br_type, jmp_type, eq, eqz, ltz, gtz, imm16, idx26, rs_val,
    input  f_pc, taken, br_cnt, taken_cnt, f_adel
  );

  modport slave (
    input  stall, d_pc, br_type, jmp_type, eq, eqz, ltz, gtz, imm16, idx26, rs_val,
    output f_pc, taken, br_cnt, taken_cnt, f_adel
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc
// Brief    : Fetch program counter with branch/jump redirect from D and
//            conditional-branch statistics. Optional fetch address check
//            enabled by macro FETCH_PC_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic       clk,
  input  logic       reset,
  fetch_pc_if.slave  bus
);

  logic [31:0] r_pc;
  logic [31:0] r_br_cnt;
  logic [31:0] r_taken_cnt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_d_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_tgt;
  logic        w_br_cond;
  logic        w_taken;
  logic        w_count;

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_d_pc_plus4 = bus.d_pc + 32'd4;
  assign w_br_off     = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign w_br_tgt     = w_d_pc_plus4 + w_br_off;
  assign w_j_tgt      = {w_d_pc_plus4[31:28], bus.idx26, 2'b00};

  // Codes 0 and 7 never satisfy a condition, so they behave as "no branch".
  always_comb begin
    w_br_cond = 1'b0;
    case (bus.br_type)
      3'd1:    w_br_cond = bus.eq;
      3'd2:    w_br_cond = ~bus.eq;
      3'd3:    w_br_cond = bus.ltz | bus.eqz;
      3'd4:    w_br_cond = bus.gtz;
      3'd5:    w_br_cond = bus.ltz;
      3'd6:    w_br_cond = ~bus.ltz;
      default: w_br_cond = 1'b0;
    endcase
  end

  // Jumps win over branches; reserved jump code 3 falls through to the branch path.
  always_comb begin
    w_taken = 1'b0;
    w_tgt   = w_br_tgt;
    case (bus.jmp_type)
      2'd1: begin
        w_taken = 1'b1;
        w_tgt   = w_j_tgt;
      end
      2'd2: begin
        w_taken = 1'b1;
        w_tgt   = bus.rs_val;
      end
      default: begin
        w_taken = w_br_cond;
        w_tgt   = w_br_tgt;
      end
    endcase
  end

  assign w_count = (bus.br_type != 3'd0) && (bus.br_type != 3'd7) && (bus.jmp_type == 2'd0);

  // A stalled redirect is simply dropped; D holds the instruction and re-presents it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_br_cnt    <= 32'd0;
      r_taken_cnt <= 32'd0;
    end else if (!bus.stall) begin
      r_pc <= w_taken ? w_tgt : w_pc_plus4;
      if (w_count) begin
        r_br_cnt <= r_br_cnt + 32'd1;
        if (w_br_cond) begin
          r_taken_cnt <= r_taken_cnt + 32'd1;
        end
      end
    end
  end

  assign bus.f_pc      = r_pc;
  assign bus.taken     = w_taken;
  assign bus.br_cnt    = r_br_cnt;
  assign bus.taken_cnt = r_taken_cnt;

`ifdef FETCH_PC_ALIGN_CHECK_EN
  localparam logic [31:0] c_ADDR_LO = 32'h0000_3000;
  localparam logic [31:0] c_ADDR_HI = 32'h0000_6FFC;

  assign bus.f_adel = ~reset & ((r_pc[1:0] != 2'b00) || (r_pc < c_ADDR_LO) || (r_pc > c_ADDR_HI));
`else
  assign bus.f_adel = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc
// Brief    : Directed and randomized checks of fetch_pc against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc;

  localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_pc_if bus ();

  fetch_pc #(.RESET_PC(c_RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_cond(input logic [2:0] bt, input logic e, input logic z,
                                  input logic l, input logic g);
    case (bt)
      3'd1:    return e;
      3'd2:    return !e;
      3'd3:    return l || z;
      3'd4:    return g;
      3'd5:    return l;
      3'd6:    return !l;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_taken();
    if (bus.jmp_type == 2'd1 || bus.jmp_type == 2'd2) return 1'b1;
    return m_cond(bus.br_type, bus.eq, bus.eqz, bus.ltz, bus.gtz);
  endfunction

  function automatic logic [31:0] m_target();
    logic signed [31:0] off;
    if (bus.jmp_type == 2'd1)
      return ((bus.d_pc + 32'd4) & 32'hF000_0000) | (32'(bus.idx26) * 32'd4);
    if (bus.jmp_type == 2'd2)
      return bus.rs_val;
    off = 32'(signed'(bus.imm16));
    return bus.d_pc + 32'd4 + 32'(off * 4);
  endfunction

  function automatic logic m_adel(input logic [31:0] pc);
`ifdef FETCH_PC_ALIGN_CHECK_EN
    if (reset) return 1'b0;
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] m_pc = c_RESET_PC;
  logic [31:0] m_br = 32'd0;
  logic [31:0] m_tk = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = c_RESET_PC;
      m_br = 32'd0;
      m_tk = 32'd0;
    end else if (!bus.stall) begin
      if (bus.jmp_type == 2'd0 && bus.br_type >= 3'd1 && bus.br_type <= 3'd6) begin
        m_br = m_br + 32'd1;
        if (m_cond(bus.br_type, bus.eq, bus.eqz, bus.ltz, bus.gtz)) m_tk = m_tk + 32'd1;
      end
      m_pc = m_taken() ? m_target() : m_pc + 32'd4;
    end
  end

  // Single per-cycle compare process, away from the active edge.
  always @(negedge clk) begin
    chk("model_f_pc",      bus.f_pc,      m_pc);
    chk("model_br_cnt",    bus.br_cnt,    m_br);
    chk("model_taken_cnt", bus.taken_cnt, m_tk);
    chk("model_taken",     32'(bus.taken),  32'(m_taken()));
    chk("model_f_adel",    32'(bus.f_adel), 32'(m_adel(bus.f_pc)));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall    = 1'b0;
    bus.br_type  = 3'd0;
    bus.jmp_type = 2'd0;
    bus.eq = 1'b0; bus.eqz = 1'b0; bus.ltz = 1'b0; bus.gtz = 1'b0;
  endtask

  logic exp_adel;

  initial begin
    reset = 1'b1;
    idle();
    bus.d_pc = 32'h0; bus.imm16 = 16'h0; bus.idx26 = 26'h0; bus.rs_val = 32'h0;
    #1;
    chk("rst_f_pc",   bus.f_pc, 32'h3000);
    chk("rst_br_cnt", bus.br_cnt, 32'h0);
    chk("rst_f_adel", 32'(bus.f_adel), 32'h0);
    step(); step();
    #2 reset = 1'b0;
    chk("rel_f_pc", bus.f_pc, 32'h3000);
    step(); chk("seq_1", bus.f_pc, 32'h3004);
    step(); chk("seq_2", bus.f_pc, 32'h3008);
    step(); chk("seq_3", bus.f_pc, 32'h300C);
    chk("seq_tk_cnt", bus.taken_cnt, 32'h0);

    // beq taken with a negative offset
    bus.d_pc = 32'h3004; bus.br_type = 3'd1; bus.eq = 1'b1; bus.imm16 = 16'hFFFF;
    #1 chk("beq_taken", 32'(bus.taken), 32'h1);
    step();
    chk("beq_f_pc", bus.f_pc, 32'h3004);
    chk("beq_br_cnt", bus.br_cnt, 32'h1);
    chk("beq_tk_cnt", bus.taken_cnt, 32'h1);

    idle();
    step(); step(); step();
    chk("pre_bne_f_pc", bus.f_pc, 32'h3010);
    bus.br_type = 3'd2; bus.eq = 1'b1;
    #1 chk("bne_taken", 32'(bus.taken), 32'h0);
    step();
    chk("bne_f_pc", bus.f_pc, 32'h3014);
    chk("bne_br_cnt", bus.br_cnt, 32'h2);
    chk("bne_tk_cnt", bus.taken_cnt, 32'h1);

    // jr to a misaligned address, stalled twice first
    idle();
    bus.jmp_type = 2'd2; bus.rs_val = 32'h0000_3001; bus.stall = 1'b1;
    step(); chk("jr_hold1", bus.f_pc, 32'h3014);
    step(); chk("jr_hold2", bus.f_pc, 32'h3014);
    bus.stall = 1'b0;
    step(); chk("jr_f_pc", bus.f_pc, 32'h3001);
`ifdef FETCH_PC_ALIGN_CHECK_EN
    exp_adel = 1'b1;
`else
    exp_adel = 1'b0;
`endif
    chk("jr_f_adel", 32'(bus.f_adel), 32'(exp_adel));
    chk("jr_br_cnt", bus.br_cnt, 32'h2);

    // j beats a concurrent branch code
    idle();
    bus.jmp_type = 2'd1; bus.br_type = 3'd4; bus.gtz = 1'b0;
    bus.d_pc = 32'h3000; bus.idx26 = 26'h0000C10;
    #1 chk("j_taken", 32'(bus.taken), 32'h1);
    step();
    chk("j_f_pc", bus.f_pc, 32'h3040);
    chk("j_br_cnt", bus.br_cnt, 32'h2);

    // asynchronous reset between edges, with a redirect pending
    idle();
    bus.jmp_type = 2'd2; bus.rs_val = 32'h3400;
    step(); chk("pre_arst_f_pc", bus.f_pc, 32'h3400);
    #2 reset = 1'b1;
    #1 chk("arst_f_pc", bus.f_pc, 32'h3000);
    chk("arst_br_cnt", bus.br_cnt, 32'h0);
    step();
    #2 reset = 1'b0;
    idle();
    step(); chk("arst_resume", bus.f_pc, 32'h3004);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      int r;
      bus.stall   = ($urandom_range(0, 3) == 0);
      bus.br_type = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      bus.jmp_type = (r <= 5) ? 2'd0 : (r <= 7) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      if (bus.jmp_type == 2'd3) bus.br_type = 3'd0;
      bus.eq  = 1'($urandom); bus.eqz = 1'($urandom);
      bus.ltz = 1'($urandom); bus.gtz = 1'($urandom);
      bus.d_pc   = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
      bus.imm16  = 16'($urandom);
      bus.idx26  = 26'($urandom);
      bus.rs_val = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 32'hFFF)) * 4;
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
        #(10 * $urandom_range(0, 2) + 1) reset = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
